uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (8N1, 16x oversampled `uartTX`) between NUM_REQ requesters.
- Grants are round-robin and held for a whole frame (a byte sequence ending with `last`).
- Sequences the transmitter: one start pulse per byte, then waits for its done pulse before the next byte.
- Sits between the debug/command producers and the single `uartTX` instance in the top level.

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 uartTX between NUM_REQ byte producers, holding the grant for a whole frame.
// Optional macro UART_ARB_HEADER_EN: each frame starts with a header byte {1, zero pad, owner index}.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_LEN    = 8,
  parameter int unsigned GAP_TIMEOUT = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*DATA_LEN-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]          i_req_last,
  output logic [NUM_REQ-1:0]          o_req_ack,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic                        o_tx_start,
  output logic [DATA_LEN-1:0]         o_tx_data,
  input  logic                        i_tx_done,
  output logic                        o_busy,
  output logic                        o_abort
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
`ifdef UART_ARB_HEADER_EN
    HDR,
`endif
    LOAD,
    START,
    WAIT,
    REL
  } stateType;

  stateType             state, stateNxt;
  logic [IDX_W-1:0]     lastGrant, lastGrantNxt;
  logic [IDX_W-1:0]     grantIdx, grantIdxNxt;
  logic [GAP_W-1:0]     gapCnt, gapCntNxt;
  logic                 lastQ, lastQNxt;
  logic [NUM_REQ-1:0]   ackNxt, grantNxt;
  logic                 startNxt, busyNxt, abortNxt;
  logic [DATA_LEN-1:0]  dataNxt;
  logic [IDX_W-1:0]     pickIdx;
  logic                 pickValid;

  function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W-1:0] base, input int unsigned off);
    return IDX_W'((32'(base) + off) % NUM_REQ);
  endfunction

`ifdef UART_ARB_HEADER_EN
  function automatic logic [DATA_LEN-1:0] hdrByte(input logic [IDX_W-1:0] idx);
    logic [DATA_LEN-1:0] b;
    b = '0;
    b[DATA_LEN-1] = 1'b1;
    b[IDX_W-1:0]  = idx;
    return b;
  endfunction
`endif

  // Round-robin pick: scan from lastGrant+1 upward; lastGrant itself is checked last.
  always_comb begin
    pickIdx   = '0;
    pickValid = 1'b0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      if (i_req[wrapIdx(lastGrant, k)]) begin
        pickIdx   = wrapIdx(lastGrant, k);
        pickValid = 1'b1;
      end
    end
  end

  always_comb begin
    stateNxt     = state;
    lastGrantNxt = lastGrant;
    grantIdxNxt  = grantIdx;
    gapCntNxt    = gapCnt;
    lastQNxt     = lastQ;
    ackNxt       = '0;
    grantNxt     = o_grant;
    startNxt     = 1'b0;
    dataNxt      = o_tx_data;
    busyNxt      = o_busy;
    abortNxt     = 1'b0;
    case (state)
      IDLE: begin
        gapCntNxt = '0;
        if (pickValid) begin
          grantIdxNxt = pickIdx;
          grantNxt    = NUM_REQ'(1) << pickIdx;
          busyNxt     = 1'b1;
          lastQNxt    = 1'b0;
`ifdef UART_ARB_HEADER_EN
          stateNxt    = HDR;
`else
          stateNxt    = LOAD;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      HDR: begin
        dataNxt  = hdrByte(grantIdx);
        startNxt = 1'b1;
        stateNxt = START;
      end
`endif
      LOAD: begin
        if (i_req[grantIdx]) begin
          dataNxt  = i_req_data[32'(grantIdx)*DATA_LEN +: DATA_LEN];
          lastQNxt = i_req_last[grantIdx];
          ackNxt   = NUM_REQ'(1) << grantIdx;
          startNxt = 1'b1;
          stateNxt = START;
        end else if (gapCnt == GAP_W'(GAP_TIMEOUT - 1)) begin
          abortNxt = 1'b1;
          stateNxt = REL;
        end else begin
          gapCntNxt = gapCnt + GAP_W'(1);
        end
      end
      // o_tx_start is visible during this state
      START: begin
        gapCntNxt = '0;
        stateNxt  = WAIT;
      end
      WAIT: begin
        if (i_tx_done) stateNxt = lastQ ? REL : LOAD;
      end
      REL: begin
        lastGrantNxt = grantIdx;
        grantNxt     = '0;
        busyNxt      = 1'b0;
        gapCntNxt    = '0;
        stateNxt     = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      lastGrant  <= IDX_W'(NUM_REQ - 1);
      grantIdx   <= '0;
      gapCnt     <= '0;
      lastQ      <= 1'b0;
      o_req_ack  <= '0;
      o_grant    <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_abort    <= 1'b0;
    end else begin
      state      <= stateNxt;
      lastGrant  <= lastGrantNxt;
      grantIdx   <= grantIdxNxt;
      gapCnt     <= gapCntNxt;
      lastQ      <= lastQNxt;
      o_req_ack  <= ackNxt;
      o_grant    <= grantNxt;
      o_tx_start <= startNxt;
      o_tx_data  <= dataNxt;
      o_busy     <= busyNxt;
      o_abort    <= abortNxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester byte queues, a 10-cycle transmitter model, expected-byte queue.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DLEN   = 8;
  localparam int unsigned GAP    = 16;
  localparam int          TX_LAT = 10;
`ifdef UART_ARB_HEADER_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic                   i_clk;
  logic                   i_reset_n;
  logic [NREQ-1:0]        i_req;
  logic [NREQ*DLEN-1:0]   i_req_data;
  logic [NREQ-1:0]        i_req_last;
  logic [NREQ-1:0]        o_req_ack;
  logic [NREQ-1:0]        o_grant;
  logic                   o_tx_start;
  logic [DLEN-1:0]        o_tx_data;
  logic                   i_tx_done;
  logic                   o_busy;
  logic                   o_abort;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_LEN(DLEN), .GAP_TIMEOUT(GAP)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_req_data(i_req_data),
    .i_req_last(i_req_last), .o_req_ack(o_req_ack), .o_grant(o_grant),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_abort(o_abort)
  );

  typedef struct { int k; logic [7:0] d; logic last; } stimT;
  typedef struct { int k; logic [7:0] d; bit hdr; } expT;

  stimT           stimQ[$];
  expT            expQ[$];
  logic [NREQ-1:0] grantLog[$];
  int             riseCycLog[$];
  int             ackCnt [NREQ];
  int             numChecks = 0, numErrors = 0;
  int             cyc = 0, txCnt = 0, lastDoneCyc = 0, lastStartGap = 0;
  int             abortCnt = 0, abortGap = 0, abortCyc = 0;
  logic [NREQ-1:0] prevGrant = '0;
  logic [NREQ-1:0] ackExp;
  bit             found;
  expT            e;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    numChecks++;
    if (got !== want) begin
      numErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Queues a requester byte and its expected transmission (header first when compiled in).
  task automatic sendByte(input int k, input logic [7:0] d, input logic last, input bit first);
    if (first && HDR_ON) expQ.push_back('{k, 8'h80 | 8'(k), 1'b1});
    expQ.push_back('{k, d, 1'b0});
    stimQ.push_back('{k, d, last});
  endtask

  task automatic waitIdle(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge i_clk); #1;
      n++;
      done = (stimQ.size() == 0) && (expQ.size() == 0) && !o_busy && (txCnt == 0);
    end
    if (!done) check("idle_timeout", 32'(o_busy), 32'(0));
  endtask

  task automatic waitGrant(input logic [NREQ-1:0] want, input int budget);
    int n;
    n = 0;
    while (o_grant !== want && n < budget) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (o_grant !== want) check("grant_timeout", 32'(o_grant), 32'(want));
  endtask

  task automatic waitAck(input int k, input int target, input int budget);
    int n;
    n = 0;
    while (ackCnt[k] < target && n < budget) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (ackCnt[k] < target) check("ack_timeout", 32'(ackCnt[k]), 32'(target));
  endtask

  // Negedge process: scoreboard, transmitter model and requester drivers.
  initial begin
    i_req = '0; i_req_data = '0; i_req_last = '0; i_tx_done = 1'b0;
    for (int k = 0; k < NREQ; k++) ackCnt[k] = 0;
    forever begin
      @(negedge i_clk);
      cyc++;
      i_tx_done = 1'b0;
      if (i_reset_n) begin
        if (txCnt > 0) begin
          txCnt--;
          if (txCnt == 0) begin
            i_tx_done   = 1'b1;
            lastDoneCyc = cyc;
          end
        end
        ackExp = '0;
        if (o_tx_start) begin
          lastStartGap = cyc - lastDoneCyc;
          txCnt = TX_LAT;
          if (expQ.size() == 0) begin
            check("tx_extra_start", 32'(expQ.size()), 32'(1));
          end else begin
            e = expQ.pop_front();
            check("tx_data", 32'(o_tx_data), 32'(e.d));
            check("tx_owner", 32'(o_grant), 32'(1 << e.k));
            ackExp = e.hdr ? '0 : NREQ'(1 << e.k);
          end
        end
        if (o_tx_start || o_req_ack != '0) check("ack", 32'(o_req_ack), 32'(ackExp));
        for (int k = 0; k < NREQ; k++) begin
          if (o_req_ack[k]) begin
            ackCnt[k]++;
            for (int i = 0; i < stimQ.size(); i++) begin
              if (stimQ[i].k == k) begin
                stimQ.delete(i);
                break;
              end
            end
          end
        end
        if (o_abort) begin
          abortCnt++;
          abortCyc = cyc;
          abortGap = cyc - lastDoneCyc;
        end
        if (prevGrant == '0 && o_grant != '0) begin
          grantLog.push_back(o_grant);
          riseCycLog.push_back(cyc);
        end
        prevGrant = o_grant;
      end
      i_req = '0;
      i_req_last = '0;
      for (int k = 0; k < NREQ; k++) begin
        found = 1'b0;
        for (int i = 0; i < stimQ.size(); i++) begin
          if (!found && stimQ[i].k == k) begin
            found = 1'b1;
            i_req[k] = 1'b1;
            i_req_data[k*DLEN +: DLEN] = stimQ[i].d;
            i_req_last[k] = stimQ[i].last;
          end
        end
      end
    end
  end

  initial begin
    int base0, base1, base3, abortBase;
    i_reset_n = 1'b1;
    #1 i_reset_n = 1'b0;

    // Reset with all four requesting; these frames are round-robin round 1.
    for (int k = 0; k < NREQ; k++) sendByte(k, 8'(8'h10 + k), 1'b1, 1'b1);
    repeat (3) begin
      @(posedge i_clk); #1;
      check("rst_grant", 32'(o_grant), 32'(0));
      check("rst_busy", 32'(o_busy), 32'(0));
      check("rst_start", 32'(o_tx_start), 32'(0));
      check("rst_ack", 32'(o_req_ack), 32'(0));
      check("rst_abort", 32'(o_abort), 32'(0));
      check("rst_data", 32'(o_tx_data), 32'(0));
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    check("grant_after_rst", 32'(o_grant), 32'(4'b0001));
    check("busy_after_rst", 32'(o_busy), 32'(1));
    waitIdle(3000);

    // Round-robin round 2.
    for (int k = 0; k < NREQ; k++) sendByte(k, 8'(8'h20 + k), 1'b1, 1'b1);
    waitIdle(3000);
    check("rr_count", 32'(grantLog.size()), 32'(8));
    for (int i = 0; i < grantLog.size() && i < 8; i++)
      check("rr_order", 32'(grantLog[i]), 32'(1 << (i % 4)));

    // Single requester, two-byte frame.
    base1 = ackCnt[1];
    sendByte(1, 8'hA5, 1'b0, 1'b1);
    sendByte(1, 8'h3C, 1'b1, 1'b0);
    waitIdle(3000);
    check("single_acks", 32'(ackCnt[1] - base1), 32'(2));
    check("single_gap", 32'(lastStartGap), 32'(2));
    check("single_grant", 32'(o_grant), 32'(0));
    check("single_busy", 32'(o_busy), 32'(0));

    // Gap timeout on requester 2; 3 and 0 queue up behind it.
    grantLog.delete();
    riseCycLog.delete();
    abortBase = abortCnt;
    sendByte(2, 8'h11, 1'b0, 1'b1);
    waitGrant(4'b0100, 200);
    sendByte(3, 8'h33, 1'b1, 1'b1);
    sendByte(0, 8'h44, 1'b1, 1'b1);
    waitIdle(3000);
    check("abort_count", 32'(abortCnt - abortBase), 32'(1));
    check("abort_timing", 32'(abortGap), 32'(GAP + 1));
    check("abort_rr_count", 32'(grantLog.size()), 32'(3));
    if (grantLog.size() >= 3) begin
      check("abort_rr0", 32'(grantLog[0]), 32'(4'b0100));
      check("abort_rr1", 32'(grantLog[1]), 32'(4'b1000));
      check("abort_rr2", 32'(grantLog[2]), 32'(4'b0001));
      check("abort_regrant", 32'(riseCycLog[1] - abortCyc), 32'(2));
    end

    // Mid-frame contention: requester 1 arrives while requester 0's second byte is in flight.
    grantLog.delete();
    base0 = ackCnt[0];
    base1 = ackCnt[1];
    sendByte(0, 8'hD1, 1'b0, 1'b1);
    sendByte(0, 8'hD2, 1'b0, 1'b0);
    sendByte(0, 8'hD3, 1'b1, 1'b0);
    waitAck(0, base0 + 2, 500);
    sendByte(1, 8'hE1, 1'b1, 1'b1);
    waitIdle(3000);
    check("cont_acks0", 32'(ackCnt[0] - base0), 32'(3));
    check("cont_acks1", 32'(ackCnt[1] - base1), 32'(1));
    check("cont_grants", 32'(grantLog.size()), 32'(2));
    if (grantLog.size() >= 2) begin
      check("cont_first", 32'(grantLog[0]), 32'(4'b0001));
      check("cont_second", 32'(grantLog[1]), 32'(4'b0010));
    end

    // Requester 3 single byte (header 0x83 precedes it when compiled in).
    base3 = ackCnt[3];
    sendByte(3, 8'h42, 1'b1, 1'b1);
    waitIdle(3000);
    check("hdr_acks", 32'(ackCnt[3] - base3), 32'(1));

    check("exp_left", 32'(expQ.size()), 32'(0));
    check("stim_left", 32'(stimQ.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
